// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, arbiter FSM encoding and default datapath width.
package alu_pkg;
    localparam int ALU_WIDTH = 16;
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_NEGA = 3'b110;
    localparam logic [2:0] OP_NEGB = 3'b111;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; ALU_ARB_LOCK_EN restricts eligibility to a locking requester.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       pointer,
`ifdef ALU_ARB_LOCK_EN
    input  logic       lock,
    input  logic       lock_id,
`endif
    output logic [1:0] grant,
    output logic       next_pointer
);
    logic [1:0] eligible;
    logic       advance;
`ifdef ALU_ARB_LOCK_EN
    assign eligible     = lock ? valid & (lock_id ? 2'b10 : 2'b01) : valid;
    assign next_pointer = lock ? pointer : advance;
`else
    assign eligible     = valid;
    assign next_pointer = advance;
`endif
    assign grant   = &eligible ? (pointer ? 2'b10 : 2'b01) : eligible;
    assign advance = grant[0] ? 1'b1 : grant[1] ? 1'b0 : pointer;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two valid/ready requesters with round-robin grant.
// Optional ALU_ARB_LOCK_EN adds per-requester lock inputs for atomic multi-op sequences.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
`ifdef ALU_ARB_LOCK_EN
    input  logic             req0_lock,
    input  logic             req1_lock,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    output logic             rsp_carry
);
    logic [1:0] state;
    logic [1:0] grant;
    logic       pointer;
    logic       next_pointer;
    logic       id;
    logic       accept;
`ifdef ALU_ARB_LOCK_EN
    logic lock;
    logic lock_id;
`endif

    rr_arb2 u_arb (
        .valid        ({req1_valid, req0_valid}),
        .pointer      (pointer),
`ifdef ALU_ARB_LOCK_EN
        .lock         (lock),
        .lock_id      (lock_id),
`endif
        .grant        (grant),
        .next_pointer (next_pointer)
    );

    assign req0_ready = state == IDLE && grant[0];
    assign req1_ready = state == IDLE && grant[1];
    assign accept     = req0_ready | req1_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pointer   <= 1'b0;
            id        <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= '0;
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            lock      <= 1'b0;
            lock_id   <= 1'b0;
`endif
        end else if (accept) begin
            alu_a   <= grant[1] ? req1_a : req0_a;
            alu_b   <= grant[1] ? req1_b : req0_b;
            alu_op  <= grant[1] ? req1_op : req0_op;
            id      <= grant[1];
            pointer <= next_pointer;
            state   <= EXEC;
`ifdef ALU_ARB_LOCK_EN
            lock    <= grant[1] ? req1_lock : req0_lock;
            lock_id <= grant[1];
`endif
        end else if (state == EXEC) begin
            // carry is only meaningful from the ALU on an add
            rsp_y     <= alu_y;
            rsp_zero  <= alu_zero;
            rsp_carry <= alu_carry && alu_op == OP_ADD;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= RESP;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
        end
    end
endmodule
